// File: rtl/buffer_pkg.sv
// Shared helpers for the buffered round-robin merge.
// Width derivation and elaboration-time parameter checks.
package buffer_pkg;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/buffer_merge_if.sv
// Handshake bundle for buffer_merge: packed input lanes,
// merged tagged output and per-lane status flags.
interface buffer_merge_if
  import buffer_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  localparam int CH_W = clog2_min1(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] A;
  logic [CHANNELS-1:0]       A_VALID;
  logic [CHANNELS-1:0]       A_READY;
  logic [WIDTH-1:0]          X;
  logic [CH_W-1:0]           X_CH;
  logic                      X_VALID;
  logic                      X_READY;
  logic [CHANNELS-1:0]       FULL;
  logic [CHANNELS-1:0]       EMPTY;

  modport slave (
    input  A, A_VALID, X_READY,
    output A_READY, X, X_CH, X_VALID,
    output FULL, EMPTY
  );

  modport master (
    output A, A_VALID, X_READY,
    input  A_READY, X, X_CH, X_VALID,
    input  FULL, EMPTY
  );
endinterface

// File: rtl/buffer_fifo.sv
// Single-lane synchronous FIFO with registered
// full/empty flags; push is ignored when full.
module buffer_fifo
  import buffer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW   = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr;
  logic [AW-1:0]    rd;
  logic [AW:0]      cnt;
  logic [AW:0]      cnt_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd];

  always_comb begin
    cnt_nxt = cnt;
    case ({do_push, do_pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr    <= '0;
      rd    <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop)  rd <= rd + 1'b1;
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == (AW+1)'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= din;
  end
endmodule

// File: rtl/buffer_merge.sv
// Per-lane FIFOs merged round-robin onto one
// registered output tagged with its source lane.
module buffer_merge
  import buffer_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 4
) (
  input logic           CLK,
  input logic           RST_N,
  buffer_merge_if.slave bus
);
  localparam int CH_W = clog2_min1(CHANNELS);

  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and >= 2");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_ch
    $error("CHANNELS must be in 1..16");
  end

  logic [WIDTH-1:0]    dout [CHANNELS];
  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] empty;
  logic [CHANNELS-1:0] a_ready;
  logic [CHANNELS-1:0] pop;
  logic [CH_W-1:0]     rr;
  logic [CH_W-1:0]     gnt;
  logic                gnt_ok;
  logic                can_load;
  logic                take;
  logic [WIDTH-1:0]    x;
  logic [CH_W-1:0]     xch;
  logic                xv;

  assign a_ready = ~full & {CHANNELS{RST_N}};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    buffer_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (CLK),
      .rst_n (RST_N),
      .push  (bus.A_VALID[i] && a_ready[i]),
      .pop   (pop[i]),
      .din   (bus.A[i*WIDTH +: WIDTH]),
      .dout  (dout[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // first non-empty lane at or above rr, wrapping
  always_comb begin
    int idx;
    idx    = 0;
    gnt_ok = 1'b0;
    gnt    = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(rr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!gnt_ok && !empty[idx]) begin
        gnt_ok = 1'b1;
        gnt    = CH_W'(idx);
      end
    end
  end

  assign can_load = !xv || bus.X_READY;
  assign take     = can_load && gnt_ok;

  always_comb begin
    pop = '0;
    if (take) pop[gnt] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      x   <= '0;
      xch <= '0;
      xv  <= 1'b0;
      rr  <= '0;
    end else if (take) begin
      x   <= dout[gnt];
      xch <= gnt;
      xv  <= 1'b1;
      rr  <= (gnt == CH_W'(CHANNELS-1))
             ? '0 : gnt + 1'b1;
    end else if (can_load) begin
      xv  <= 1'b0;
    end
  end

  assign bus.A_READY = a_ready;
  assign bus.FULL    = full;
  assign bus.EMPTY   = empty;
  assign bus.X       = x;
  assign bus.X_CH    = xch;
  assign bus.X_VALID = xv;
endmodule

// File: tb/tb_buffer_merge.sv
// Directed bench for buffer_merge: reset, latency,
// fill/stall, hold, mid-run reset and fairness.
module tb_buffer_merge;
  localparam int W = 16;
  localparam int D = 4;
  localparam int C = 4;

  logic CLK = 1'b0;
  logic RST_N;

  always #5 CLK = ~CLK;

  buffer_merge_if #(.WIDTH(W), .CHANNELS(C)) bif ();

  buffer_merge #(
    .WIDTH    (W),
    .DEPTH    (D),
    .CHANNELS (C)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bif)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input int c,
                     input logic [15:0] d);
    bif.A[c*W +: W] = d;
  endtask

  initial begin
    int seq [C];
    logic [C-1:0] rdy;
    int ch;

    RST_N       = 1'b0;
    bif.A       = '0;
    bif.A_VALID = '1;
    bif.X_READY = 1'b1;
    for (int c = 0; c < C; c++) seq[c] = 0;

    // reset held with all inputs valid
    repeat (3) step();
    check("rst_aready", bif.A_READY, 4'h0);
    check("rst_xvalid", bif.X_VALID, 0);
    check("rst_x", bif.X, 0);
    check("rst_xch", bif.X_CH, 0);
    check("rst_empty", bif.EMPTY, 4'hF);
    check("rst_full", bif.FULL, 4'h0);
    bif.A_VALID = '0;
    RST_N = 1'b1;
    step();
    check("rel_aready", bif.A_READY, 4'hF);

    // single word on lane 2, two-cycle latency
    put(2, 16'hA5A5);
    bif.A_VALID = 4'b0100;
    step();
    bif.A_VALID = '0;
    check("s_empty", bif.EMPTY, 4'b1011);
    check("s_lat", bif.X_VALID, 0);
    step();
    check("s_xvalid", bif.X_VALID, 1);
    check("s_x", bif.X, 16'hA5A5);
    check("s_xch", bif.X_CH, 2);
    check("s_drained", bif.EMPTY, 4'hF);
    step();
    check("s_idle", bif.X_VALID, 0);
    check("s_xhold", bif.X, 16'hA5A5);

    // fill lane 0 with the consumer stalled
    bif.X_READY = 1'b0;
    bif.A_VALID = 4'b0001;
    for (int w = 0; w < 5; w++) begin
      put(0, 16'h1000 + 16'(w));
      step();
    end
    check("f_x", bif.X, 16'h1000);
    check("f_full", bif.FULL, 4'b0001);
    check("f_aready", bif.A_READY, 4'b1110);
    put(0, 16'h1005);
    for (int k = 0; k < 5; k++) begin
      step();
      check("h_x", bif.X, 16'h1000);
      check("h_xch", bif.X_CH, 0);
      check("h_xvalid", bif.X_VALID, 1);
      check("h_full", bif.FULL, 4'b0001);
      check("h_empty", bif.EMPTY, 4'b1110);
    end
    bif.X_READY = 1'b1;
    step();
    bif.X_READY = 1'b0;
    check("p_x", bif.X, 16'h1001);
    check("p_full", bif.FULL, 4'b0000);
    check("p_aready", bif.A_READY, 4'hF);
    step();
    bif.A_VALID = '0;
    check("p_refull", bif.FULL, 4'b0001);
    bif.X_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("d_x", bif.X, 16'h1002 + 16'(k));
      check("d_xvalid", bif.X_VALID, 1);
    end
    step();
    check("d_idle", bif.X_VALID, 0);
    check("d_empty", bif.EMPTY, 4'hF);

    // partial fill then reset mid-operation
    bif.X_READY = 1'b0;
    put(0, 16'h0A00);
    put(1, 16'h1A00);
    put(2, 16'h2A00);
    bif.A_VALID = 4'b0111;
    step();
    step();
    bif.A_VALID = '0;
    check("m_xch", bif.X_CH, 1);
    check("m_x", bif.X, 16'h1A00);
    RST_N = 1'b0;
    step();
    check("m_empty", bif.EMPTY, 4'hF);
    check("m_full", bif.FULL, 4'h0);
    check("m_xvalid", bif.X_VALID, 0);
    check("m_x0", bif.X, 0);
    check("m_aready", bif.A_READY, 4'h0);
    RST_N = 1'b1;
    bif.X_READY = 1'b1;
    put(0, 16'h0C00);
    put(3, 16'h3C03);
    bif.A_VALID = 4'b1001;
    step();
    bif.A_VALID = '0;
    check("r_lat", bif.X_VALID, 0);
    step();
    check("r_xch0", bif.X_CH, 0);
    check("r_x0", bif.X, 16'h0C00);
    step();
    check("r_xch3", bif.X_CH, 3);
    check("r_x3", bif.X, 16'h3C03);
    step();
    check("r_idle", bif.X_VALID, 0);

    // fill every lane, then drain round-robin
    bif.X_READY = 1'b0;
    bif.A_VALID = '1;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < C; c++)
        put(c, 16'((c << 12) | 16'h100 | seq[c]));
      rdy = bif.A_READY;
      step();
      for (int c = 0; c < C; c++)
        if (rdy[c]) seq[c]++;
      if (bif.FULL == 4'hF) break;
    end
    bif.A_VALID = '0;
    check("a_full", bif.FULL, 4'hF);
    check("a_x", bif.X, 16'h0100);
    check("a_xch", bif.X_CH, 0);
    bif.X_READY = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      ch = (k + 1) % C;
      check("rr_xch", bif.X_CH, 32'(ch));
      check("rr_x", bif.X,
            32'((ch << 12) | 16'h100 | ((k + 1) / 4)));
      check("rr_xvalid", bif.X_VALID, 1);
    end
    step();
    check("rr_idle", bif.X_VALID, 0);
    check("rr_empty", bif.EMPTY, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/buffer_merge.md
Name: buffer_merge

Overview:
- Parametrised successor to the single-bit BUFFER cell: CHANNELS independent buffered input lanes, each WIDTH bits wide and DEPTH entries deep.
- Lanes are merged round-robin onto one registered output bus tagged with the source channel number.
- Sits between multi-source netlist blocks (packed/concatenated buses) and a single consumer; valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, data bits per channel.
- DEPTH, 4, entries per channel FIFO; power of 2, >= 2.
- CHANNELS, 4, number of input lanes; 1..16.
- CH_W, max(1,$clog2(CHANNELS)), width of channel tag (derived, not overridden).

Ports:
- CLK  input  1  sole clock; all state updates on rising edge.
- RST_N  input  1  synchronous, active-low reset.
- A  input  CHANNELS*WIDTH  packed input data; channel i at bits [i*WIDTH +: WIDTH].
- A_VALID  input  CHANNELS  per-channel input valid.
- A_READY  output  CHANNELS  per-channel input ready.
- X  output  WIDTH  merged output data.
- X_CH  output  CH_W  channel index of the word on X.
- X_VALID  output  1  output valid.
- X_READY  input  1  output ready from consumer.
- FULL  output  CHANNELS  per-channel FIFO full flag.
- EMPTY  output  CHANNELS  per-channel FIFO empty flag.

Behaviour:
- Reset (RST_N low at a rising edge): all FIFO pointers and counts 0; X=0, X_CH=0, X_VALID=0; round-robin pointer=0; EMPTY all 1, FULL all 0.
- A_READY is forced 0 while RST_N is low, regardless of FIFO state.
- Reset mid-transfer discards all buffered words and any word held on X. No partial state survives.
- Push: channel i stores A[i] when A_VALID[i] && A_READY[i].
- A_READY[i] = !FULL[i] && RST_N. It has no combinational path from X_READY.
- A push into a full FIFO cannot occur, even if that FIFO is popped in the same cycle. A full channel accepts again one cycle after its pop.
- Per-channel FIFO: pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits. FULL when count==DEPTH, EMPTY when count==0. All flags are registered.
- Output register load: the output register "can load" when !X_VALID || X_READY.
- When it can load and some channel is non-empty, the arbiter grants the first non-empty channel, searching from the round-robin pointer upward modulo CHANNELS.
- On a grant: pop that channel, load X/X_CH, set X_VALID=1, and set the round-robin pointer to grant+1 (mod CHANNELS).
- When it can load and all channels are empty: X_VALID goes to 0 and X/X_CH hold their last values.
- Hold rule: while X_VALID && !X_READY, X and X_CH are stable and no pop occurs.
- Throughput: one word per cycle sustained when X_READY is held high and any channel is non-empty.
- Latency: a word pushed at edge t is visible on X no earlier than after edge t+1 (2 cycles from the A_VALID cycle to X_VALID). No bypass of an empty FIFO.
- Simultaneous push and pop on the same channel in one cycle leaves the count unchanged; both pointers advance.
- A push into an empty FIFO at edge t is not eligible for arbitration until the cycle after t.
- CHANNELS==1: the arbiter degenerates to always granting channel 0; X_CH is constant 0.

Decomposition:
- Shared package buffer_pkg: function clog2_min1 (used for CH_W and pointer widths); localparam checks (DEPTH power of 2, CHANNELS range) asserted at elaboration.
- Sub-module buffer_fifo (WIDTH, DEPTH): single-channel synchronous FIFO with push/pop/full/empty/count. Instantiated CHANNELS times in a generate loop.
- Top level holds the round-robin arbiter and the output register.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles with A_VALID=all 1 -> A_READY=0, X_VALID=0, X=0, EMPTY=4'b1111. After release, A_READY=4'b1111 at the next cycle.
- Single channel: push 0xA5A5 on channel 2 at cycle 0 -> X_VALID=1, X=0xA5A5, X_CH=2 after edge 1.
- Fill and stall: X_READY=0, push 5 words on channel 0 -> FULL[0]=1 and A_READY[0]=0 after the 4th stored word (one word on X, DEPTH=4 in FIFO). The 5th word is accepted only after X_READY pulses.
- Fairness: all four channels full, X_READY=1 -> X_CH sequence 0,1,2,3,0,1,2,3,... with one word per cycle and no gaps for 16 cycles.
- Backpressure hold: X_READY=0 for 5 cycles while X_VALID=1 -> X and X_CH unchanged each cycle, no EMPTY/FULL change from pops.
- Mid-operation reset: RST_N=0 for one edge with 3 channels partially full -> next cycle EMPTY=all 1, X_VALID=0, round-robin restarts at channel 0.
